// File: rtl/fir_output_requantizer.sv
// Output stage of the pipelined FIR: decimate, round, shift and saturate the
// wide accumulator, then buffer results in a small FWFT FIFO toward the sink.
module fir_output_requantizer #(
    parameter int unsigned DATA_IN_WIDTH  = 64,
    parameter int unsigned DATA_OUT_WIDTH = 16,
    parameter int unsigned SHIFT          = 31,
    parameter int unsigned DECIM          = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    input  logic                      flag_clr,
    output logic                      sat_flag,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned W1 = DATA_IN_WIDTH + 1;
    localparam int unsigned OW = DATA_OUT_WIDTH;
    localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [W1-1:0] ONE = {{(W1-1){1'b0}}, 1'b1};
    // Half-LSB rounding constant; collapses to zero when SHIFT is 0.
    localparam logic [W1-1:0] RND = (ONE << SHIFT) >> 1;
    localparam logic signed [W1-1:0] MAXV = {{(W1-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [W1-1:0] MINV = {{(W1-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // ---------------- decimation ----------------
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          keep;

    assign keep = in_valid & (dcnt_q == '0);

    always_comb begin
        dcnt_d = dcnt_q;
        if (in_valid) begin
            if (dcnt_q == CW'(DECIM - 1)) begin
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + CW'(1);
            end
        end
    end

    // ---------------- rounding / saturation ----------------
    logic signed [W1-1:0] ext_s;
    logic signed [W1-1:0] sum_s;
    logic signed [W1-1:0] shf_s;
    logic [OW-1:0]        qval;
    logic                 qsat;

    always_comb begin
        ext_s = {data_in[DATA_IN_WIDTH-1], data_in};
        sum_s = ext_s + RND;
        shf_s = sum_s >>> SHIFT;
        qsat  = 1'b0;
        qval  = shf_s[OW-1:0];
        if (shf_s > MAXV) begin
            qval = MAXV[OW-1:0];
            qsat = 1'b1;
        end else if (shf_s < MINV) begin
            qval = MINV[OW-1:0];
            qsat = 1'b1;
        end
    end

    logic          qv_q, qv_d;
    logic [OW-1:0] qdata_q, qdata_d;
    logic          sat_q, sat_d;

    // ---------------- output FIFO ----------------
    logic [OW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    drop_q, drop_d;
    logic          full, pop, push, drop;

    assign full = (cnt_q == FULL_CNT);
    assign pop  = out_valid & out_ready;
    assign push = qv_q & (~full | pop);
    assign drop = qv_q & full & ~pop;

    always_comb begin
        qv_d    = keep;
        qdata_d = keep ? qval : qdata_q;

        // A new event in the same cycle as flag_clr must survive the clear.
        sat_d = sat_q;
        if (keep & qsat) begin
            sat_d = 1'b1;
        end else if (flag_clr) begin
            sat_d = 1'b0;
        end

        drop_d = drop_q;
        if (drop) begin
            if (flag_clr) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (flag_clr) begin
            drop_d = '0;
        end

        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (push & ~pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop & ~push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q  <= '0;
            qv_q    <= 1'b0;
            qdata_q <= '0;
            sat_q   <= 1'b0;
            drop_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            dcnt_q  <= dcnt_d;
            qv_q    <= qv_d;
            qdata_q <= qdata_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the count gates everything visible at the output.
    always_ff @(posedge clk) begin
        if (push & ~reset) begin
            mem_q[wr_q] <= qdata_q;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign data_out  = out_valid ? mem_q[rd_q] : '0;
    assign sat_flag  = sat_q;
    assign drop_cnt  = drop_q;

endmodule
